// File: rtl/pong_vga_renderer.sv
// Pong VGA renderer: 640x480@60 timing, per-frame game-state snapshot, 2-bit RGB.
// Latency: sync, rgb and frame_tick are registered one cycle behind hpos/vpos.
// Backpressure: none; inputs are sampled only at the last pixel of each frame.
module pong_vga_renderer #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int BALL_SIZE     = 10,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int NET_X         = 318,
  parameter int NET_WIDTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_y,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       frame_tick,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Object extents are compared in 11 bits so a coordinate near 1023 clips instead of wrapping.
  localparam logic [10:0] BALL_SZ = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W   = 11'(PADDLE_WIDTH);
  localparam logic [10:0] PAD_H   = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] NET_LO  = 11'(NET_X);
  localparam logic [10:0] NET_HI  = 11'(NET_X + NET_WIDTH);

  localparam logic [5:0] RGB_BALL   = 6'b11_11_11;
  localparam logic [5:0] RGB_PADDLE = 6'b00_11_00;
  localparam logic [5:0] RGB_NET    = 6'b01_01_01;
  localparam logic [5:0] RGB_BLACK  = 6'b00_00_00;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [9:0] ball_x_q, ball_y_q, paddle_y_q;
  logic       hsync_q, vsync_q, frame_tick_q;
  logic [5:0] rgb_q;

  logic       h_end, v_end, snap;
  logic       hsync_d, vsync_d, frame_tick_d, display_on;
  logic       ball_hit, paddle_hit, net_hit;
  logic [5:0] rgb_d;
  logic [10:0] h11, v11;

  // Raster position advance: hpos wraps each line, vpos steps only on the hpos wrap.
  always_comb begin
    h_end  = (hpos_q == H_LAST);
    v_end  = (vpos_q == V_LAST);
    snap   = h_end && v_end;
    hpos_d = h_end ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_end) begin
      vpos_d = v_end ? 10'd0 : vpos_q + 10'd1;
    end
  end

  // Sync, blanking and frame strobe decoded from the current counters.
  always_comb begin
    hsync_d      = !((hpos_q >= HS_START) && (hpos_q < HS_END));
    vsync_d      = !((vpos_q >= VS_START) && (vpos_q < VS_END));
    display_on   = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    frame_tick_d = (hpos_q == 10'd0) && (vpos_q == V_VIS);
  end

  // Object hit tests against the frame snapshot, then colour by priority.
  always_comb begin
    h11 = {1'b0, hpos_q};
    v11 = {1'b0, vpos_q};
    ball_hit   = (h11 >= {1'b0, ball_x_q}) && (h11 < ({1'b0, ball_x_q} + BALL_SZ)) &&
                 (v11 >= {1'b0, ball_y_q}) && (v11 < ({1'b0, ball_y_q} + BALL_SZ));
    paddle_hit = (h11 < PAD_W) &&
                 (v11 >= {1'b0, paddle_y_q}) && (v11 < ({1'b0, paddle_y_q} + PAD_H));
    net_hit    = (h11 >= NET_LO) && (h11 < NET_HI) && !vpos_q[4];
    rgb_d = RGB_BLACK;
    if (display_on) begin
      if (ball_hit) begin
        rgb_d = RGB_BALL;
      end else if (paddle_hit) begin
        rgb_d = RGB_PADDLE;
      end else if (net_hit) begin
        rgb_d = RGB_NET;
      end
    end
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q <= 10'd0;
      vpos_q <= 10'd0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Game-state snapshot at the very last pixel so a whole frame draws from one consistent state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ball_x_q   <= 10'd0;
      ball_y_q   <= 10'd0;
      paddle_y_q <= 10'd0;
    end else if (snap) begin
      ball_x_q   <= ball_x;
      ball_y_q   <= ball_y;
      paddle_y_q <= paddle_y;
    end
  end

  // Output registers keep sync and pixel data aligned one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= RGB_BLACK;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign red        = rgb_q[5:4];
  assign green      = rgb_q[3:2];
  assign blue       = rgb_q[1:0];
  assign frame_tick = frame_tick_q;
  assign hpos       = hpos_q;
  assign vpos       = vpos_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer with a scaled-down raster so many frames fit in a short run.
// Reference model works from elapsed cycles since reset and plain integer geometry.
// Inputs have no handshake; the bench changes them at arbitrary cycles.
module tb_pong_vga_renderer;

  localparam int H_VIS = 40, H_FR = 4, H_SY = 6, H_BK = 6;
  localparam int V_VIS = 30, V_FR = 3, V_SY = 2, V_BK = 5;
  localparam int HT = H_VIS + H_FR + H_SY + H_BK;   // 56
  localparam int VT = V_VIS + V_FR + V_SY + V_BK;   // 40
  localparam int BS = 4, PW = 3, PH = 6, NX = 18, NW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] ball_x = '0, ball_y = '0, paddle_y = '0;
  logic       hsync, vsync, frame_tick;
  logic [1:0] red, green, blue;
  logic [9:0] hpos, vpos;
  logic [5:0] rgb;
  assign rgb = {red, green, blue};

  int total = 0;
  int bad   = 0;

  pong_vga_renderer #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FR), .H_SYNC(H_SY), .H_BACK(H_BK),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FR), .V_SYNC(V_SY), .V_BACK(V_BK),
    .BALL_SIZE(BS), .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH),
    .NET_X(NX), .NET_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_tick(frame_tick), .hpos(hpos), .vpos(vpos)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int hof(input int t);
    return t % HT;
  endfunction

  function automatic int vof(input int t);
    return (t / HT) % VT;
  endfunction

  function automatic logic [5:0] pix(input int x, input int y, input int bx, input int by, input int py);
    if (x >= H_VIS || y >= V_VIS) return 6'h00;
    if (x >= bx && x < bx + BS && y >= by && y < by + BS) return 6'h3F;
    if (x < PW && y >= py && y < py + PH) return 6'h0C;
    if (x >= NX && x < NX + NW && ((y / 16) % 2) == 0) return 6'h15;
    return 6'h00;
  endfunction

  int         mt = 0;
  int         s_bx = 0, s_by = 0, s_py = 0;
  logic       e_hs, e_vs, e_tick;
  logic [5:0] e_rgb;
  logic       mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mt     <= 0;
      s_bx   <= 0;
      s_by   <= 0;
      s_py   <= 0;
      e_hs   <= 1'b1;
      e_vs   <= 1'b1;
      e_rgb  <= 6'h00;
      e_tick <= 1'b0;
      mvalid <= 1'b1;
    end else begin
      e_hs   <= !(hof(mt) >= H_VIS + H_FR && hof(mt) < H_VIS + H_FR + H_SY);
      e_vs   <= !(vof(mt) >= V_VIS + V_FR && vof(mt) < V_VIS + V_FR + V_SY);
      e_rgb  <= pix(hof(mt), vof(mt), s_bx, s_by, s_py);
      e_tick <= (hof(mt) == 0) && (vof(mt) == V_VIS);
      if (hof(mt) == HT - 1 && vof(mt) == VT - 1) begin
        s_bx <= int'(ball_x);
        s_by <= int'(ball_y);
        s_py <= int'(paddle_y);
      end
      mt <= mt + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      total++;
      if (hpos !== 10'(hof(mt)) || vpos !== 10'(vof(mt))) begin
        bad++;
        $display("FAIL counters @%0t: got (%0d,%0d) expected (%0d,%0d)", $time, hpos, vpos, hof(mt), vof(mt));
      end
      total++;
      if ({hsync, vsync, rgb, frame_tick} !== {e_hs, e_vs, e_rgb, e_tick}) begin
        bad++;
        $display("FAIL outputs @%0t pos(%0d,%0d): got hs=%b vs=%b rgb=%h tick=%b expected hs=%b vs=%b rgb=%h tick=%b",
                 $time, hpos, vpos, hsync, vsync, rgb, frame_tick, e_hs, e_vs, e_rgb, e_tick);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(hpos == 10'(x) && vpos == 10'(y)) && n < 3000);
    if (!(hpos == 10'(x) && vpos == 10'(y))) begin
      total++;
      bad++;
      $display("FAIL wait_pos(%0d,%0d): timed out at (%0d,%0d)", x, y, hpos, vpos);
    end
  endtask

  // Pixel (x,y) appears on the rgb outputs one cycle after the counters show it.
  task automatic probe(input int x, input int y, input logic [5:0] exp, input string name);
    wait_pos(x, y);
    @(negedge clk);
    check(name, 32'(rgb), 32'(exp));
  endtask

  // Lands on the first pixel of a frame whose snapshot was taken after this call.
  task automatic next_frame();
    wait_pos(0, VT - 1);
    wait_pos(0, 0);
  endtask

  function automatic logic [9:0] rnd();
    if ($urandom_range(0, 7) == 0) return 10'($urandom_range(0, 1023));
    return 10'($urandom_range(0, 45));
  endfunction

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset hpos", 32'(hpos), 0);
    check("reset vpos", 32'(vpos), 0);
    check("reset hsync", 32'(hsync), 1);
    check("reset vsync", 32'(vsync), 1);
    check("reset rgb", 32'(rgb), 0);
    check("reset tick", 32'(frame_tick), 0);
    rst = 1'b0;

    // hsync falls one cycle after hpos=44, low for 6, period 56
    wait_pos(44, 0);
    check("hsync before fall", 32'(hsync), 1);
    @(negedge clk);
    check("hsync fall", 32'(hsync), 0);
    n = 0;
    while (hsync == 1'b0 && n < 100) begin n++; @(negedge clk); end
    check("hsync low width", n, H_SY);
    while (hsync == 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("hsync period", n, HT);

    // frame_tick one cycle after (0,30), single pulse, period one frame
    wait_pos(0, V_VIS);
    check("tick before", 32'(frame_tick), 0);
    @(negedge clk);
    check("tick pulse", 32'(frame_tick), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 3000);
    check("frame period", n, HT * VT);
    @(negedge clk);
    check("tick one cycle", 32'(frame_tick), 0);

    // vsync low for exactly two lines starting one cycle after (0,33)
    wait_pos(0, V_VIS + V_FR);
    check("vsync before fall", 32'(vsync), 1);
    @(negedge clk);
    n = 0;
    while (vsync == 1'b0 && n < 1000) begin n++; @(negedge clk); end
    check("vsync low width", n, V_SY * HT);

    // ball and paddle rendering
    ball_x = 10; ball_y = 8; paddle_y = 12;
    next_frame();
    probe(10, 8, 6'h3F, "ball top-left");
    probe(14, 8, 6'h00, "ball right edge exclusive");
    probe(9, 9, 6'h00, "left of ball");
    probe(13, 11, 6'h3F, "ball bottom-right");
    probe(1, 12, 6'h0C, "paddle top");
    probe(1, 18, 6'h00, "below paddle");

    // overlap priority and dashed net
    ball_x = 0; ball_y = 20; paddle_y = 20;
    next_frame();
    probe(19, 0, 6'h15, "net dash on");
    probe(19, 16, 6'h00, "net dash off");
    probe(2, 21, 6'h3F, "ball over paddle");
    probe(2, 25, 6'h0C, "paddle below ball");

    // tear test: mid-frame input change waits for the next frame
    ball_x = 10; ball_y = 15; paddle_y = 0;
    next_frame();
    wait_pos(0, 12);
    ball_x = 25;
    probe(10, 15, 6'h3F, "tear old position kept");
    probe(25, 15, 6'h00, "tear new position hidden");
    next_frame();
    probe(10, 15, 6'h00, "tear old position gone");
    probe(25, 15, 6'h3F, "tear new position shown");

    // mid-frame reset restarts at (0,0) with cleared shadows
    ball_x = 30; ball_y = 25; paddle_y = 10;
    wait_pos(30, 20);
    rst = 1'b1;
    @(negedge clk);
    check("midreset hpos", 32'(hpos), 0);
    check("midreset vpos", 32'(vpos), 0);
    check("midreset syncs", 32'({hsync, vsync}), 3);
    check("midreset rgb", 32'(rgb), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset hpos", 32'(hpos), 1);
    probe(2, 0, 6'h3F, "zero shadow ball");
    probe(5, 2, 6'h00, "zero shadow background");
    probe(2, 5, 6'h0C, "zero shadow paddle");

    // randomized inputs, checked every cycle by the model
    for (int e = 0; e < 60; e++) begin
      repeat ($urandom_range(20, 400)) @(negedge clk);
      ball_x   = rnd();
      ball_y   = rnd();
      paddle_y = rnd();
      if (e == 31) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (HT * VT) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
